// File: rtl/pipe_pkg.sv
// Shared encodings for the fetch-stage sequencer: FSM states, next-PC select, reset PC.
package pipe_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SelInc  = 2'd0,
      SelBr   = 2'd1,
      SelJ    = 2'd2,
      SelHold = 2'd3
   } pc_sel_e;

   localparam int unsigned DefaultResetPc = 0;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC and the F/D, D/X latch strobes for the fetch stage.
module pc_next_mux
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  state_e             state,
   input  logic               reset,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [WIDTH-1:0]   br_target,
   input  logic               jump,
   input  logic [WIDTH-1:0]   j_target,
   input  logic               halt,
   input  logic [WIDTH-1:0]   pc,
   input  logic [WIDTH-1:0]   pc_inc,
   output logic [WIDTH-1:0]   pc_next,
   output logic               fd_en,
   output logic               flush_fd,
   output logic               flush_dx,
   output logic               go_halt,
   output logic               stall_hit,
   output logic               redir_hit
);

   pc_sel_e sel;

   always_comb begin
      sel       = SelHold;
      fd_en     = 1'b0;
      flush_fd  = 1'b0;
      flush_dx  = 1'b0;
      go_halt   = 1'b0;
      stall_hit = 1'b0;
      redir_hit = 1'b0;
      // Strobes only exist in RUN and never while reset is asserted.
      if (reset && (state == StRun)) begin
         if (br_taken) begin
            sel       = SelBr;
            flush_fd  = 1'b1;
            flush_dx  = 1'b1;
            redir_hit = 1'b1;
         end else if (stall) begin
            flush_dx  = 1'b1;
            stall_hit = 1'b1;
         end else if (jump) begin
            sel       = SelJ;
            fd_en     = 1'b1;
            flush_fd  = 1'b1;
            redir_hit = 1'b1;
         end else if (halt) begin
            flush_fd  = 1'b1;
            go_halt   = 1'b1;
         end else begin
            sel       = SelInc;
            fd_en     = 1'b1;
         end
      end
   end

   always_comb begin
      unique case (sel)
         SelInc:  pc_next = pc_inc;
         SelBr:   pc_next = br_target;
         SelJ:    pc_next = j_target;
         SelHold: pc_next = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, BOOT/RUN/HALT fetch FSM and performance counters for the 5-stage pipe.
module pc_sequencer
   import pipe_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DefaultResetPc),
   parameter int unsigned     CNT_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 br_taken,
   input  logic [WIDTH-1:0]     br_target,
   input  logic                 jump,
   input  logic [WIDTH-1:0]     j_target,
   input  logic                 halt,
   output logic [WIDTH-1:0]     address_imem,
   output logic [WIDTH-1:0]     pc_plus_one,
   output logic                 fetch_valid,
   output logic                 fd_en,
   output logic                 flush_fd,
   output logic                 flush_dx,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] redir_cnt
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic                 fetch_valid_q, halted_q;
   logic [CNT_WIDTH-1:0] cycle_cnt_q, stall_cnt_q, redir_cnt_q;
   logic                 go_halt, stall_hit, redir_hit;

   assign pc_plus_one = pc_q + WIDTH'(1);

   pc_next_mux #(
      .WIDTH(WIDTH)
   ) u_pc_next_mux (
      .state     (state_q),
      .reset     (reset),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_target (br_target),
      .jump      (jump),
      .j_target  (j_target),
      .halt      (halt),
      .pc        (pc_q),
      .pc_inc    (pc_plus_one),
      .pc_next   (pc_d),
      .fd_en     (fd_en),
      .flush_fd  (flush_fd),
      .flush_dx  (flush_dx),
      .go_halt   (go_halt),
      .stall_hit (stall_hit),
      .redir_hit (redir_hit)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   state_d = go_halt ? StHalt : StRun;
         StHalt:  state_d = StHalt;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         cycle_cnt_q   <= '0;
         stall_cnt_q   <= '0;
         redir_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= (state_d == StRun);
         halted_q      <= (state_d == StHalt);
         if (state_q != StBoot) cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
         if (stall_hit)         stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
         if (redir_hit)         redir_cnt_q <= redir_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign address_imem = pc_q;
   assign fetch_valid  = fetch_valid_q;
   assign halted       = halted_q;
   assign cycle_cnt    = cycle_cnt_q;
   assign stall_cnt    = stall_cnt_q;
   assign redir_cnt    = redir_cnt_q;

endmodule
